// File: rtl/slow_mem_pkg.sv
// Shared types and constants for the slow_mem_lat SRAM model.
package slow_mem_pkg;

    typedef enum logic {IDLE, WAIT} slow_mem_state_e;

    localparam logic [15:0] LfsrTaps = 16'hB400;

    // One step of the 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LfsrTaps) : (cur >> 1);
    endfunction

endpackage

// File: rtl/slow_mem_lfsr.sv
// Free-running 16-bit Galois LFSR; an all-zero seed is replaced by 16'h0001.
module slow_mem_lfsr
    import slow_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] seed,
    output logic [15:0] lfsr_o
);

    logic [15:0] seed_nz;

    assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_o <= seed_nz;
        end else begin
            lfsr_o <= lfsr_step(lfsr_o);
        end
    end

endmodule

// File: rtl/slow_mem_lat.sv
// SRAM model on a req/gnt/rvalid port with programmable grant stalls and response latency.
// One outstanding transaction; out-of-range addresses respond with err_o.
module slow_mem_lat
    import slow_mem_pkg::*;
#(
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MaxLatency  = 16,
    parameter int unsigned MaxGntStall = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1,
    parameter int unsigned AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned LatWidth    = $clog2(MaxLatency) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic                   rand_en_i,
    input  logic [LatWidth-1:0]    fixed_lat_i,
    output logic                   gnt_o,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o
);

    localparam int unsigned NumBytes   = DataWidth / 8;
    localparam int unsigned StallWidth = (MaxGntStall > 0) ? $clog2(MaxGntStall + 1) : 1;

    slow_mem_state_e        state_q, state_d;
    logic [LatWidth-1:0]    lat_q, lat_d, lat_sel;
    logic [StallWidth-1:0]  stall_q, stall_d;
    logic                   we_q, we_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [NumBytes-1:0]    be_q, be_d;
    logic                   rvalid_d, err_d;
    logic [DataWidth-1:0]   rdata_d, mem_rdata;
    logic                   mem_we, allow, in_range;
    logic [15:0]            lfsr;
    logic                   unused_lfsr;

    logic [DataWidth-1:0]   mem_q [NumWords];

    slow_mem_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .seed   (LfsrSeed),
        .lfsr_o (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:LatWidth-1];

    assign allow     = rand_en_i ? (lfsr[0] | (stall_q == StallWidth'(MaxGntStall))) : 1'b1;
    assign in_range  = 32'(addr_q) < NumWords;
    assign mem_rdata = mem_q[addr_q];

    // Latency chosen at grant: LFSR-derived in random mode, clamped to 1..MaxLatency otherwise.
    always_comb begin
        lat_sel = fixed_lat_i;
        if (rand_en_i) begin
            lat_sel = LatWidth'({1'b0, lfsr[LatWidth-2:0]}) + LatWidth'(1);
        end else if (fixed_lat_i == '0) begin
            lat_sel = LatWidth'(1);
        end else if (fixed_lat_i > LatWidth'(MaxLatency)) begin
            lat_sel = LatWidth'(MaxLatency);
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        stall_d  = '0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        gnt_o    = 1'b0;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_o = req_i & allow;
                if (req_i && !allow) begin
                    stall_d = stall_q + StallWidth'(1);
                end
                if (gnt_o) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    lat_d   = lat_sel;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - LatWidth'(1);
                if (lat_q <= LatWidth'(1)) begin
                    state_d  = IDLE;
                    lat_d    = '0;
                    rvalid_d = 1'b1;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            stall_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rvalid_o <= rvalid_d;
            rdata_o  <= rdata_d;
            err_o    <= err_d;
        end
    end

    // Array is not reset; byte-masked write on the response edge only.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (be_q[b]) begin
                    mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_slow_mem_lat.sv
// Directed + random scoreboard bench for slow_mem_lat (NumWords=1000, MaxLatency=16).
`timescale 1ns/1ps
module tb_slow_mem_lat;

    localparam int unsigned NumWords    = 1000;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned MaxLatency  = 16;
    localparam int unsigned MaxGntStall = 4;
    localparam int unsigned AddrWidth   = 10;
    localparam int unsigned LatWidth    = 5;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat_min;
        int          lat_max;
        int          t_gnt;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_i, we_i, rand_en_i;
    logic [AddrWidth-1:0] addr_i;
    logic [31:0]          wdata_i;
    logic [3:0]           be_i;
    logic [LatWidth-1:0]  fixed_lat_i;
    logic                 gnt_o, rvalid_o, err_o;
    logic [31:0]          rdata_o;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          b2b_cnt = 0;
    logic [31:0] model [NumWords];
    exp_t        sb [$];

    slow_mem_lat #(
        .NumWords    (NumWords),
        .DataWidth   (DataWidth),
        .MaxLatency  (MaxLatency),
        .MaxGntStall (MaxGntStall),
        .LfsrSeed    (16'hACE1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .rand_en_i   (rand_en_i),
        .fixed_lat_i (fixed_lat_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left in the low clock phase just after a negedge.
    task automatic txn(input logic we, input int addr, input logic [31:0] wd, input logic [3:0] be,
                       input bit may_withdraw, input bit perturb);
        int stall;
        int lat;
        int l_fix;
        bit granted;
        bit found;
        exp_t e;
        exp_t got;
        logic [LatWidth-1:0] save_lat;
        logic save_mode;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = AddrWidth'(addr);
        wdata_i = wd;
        be_i    = be;
        stall   = 0;
        granted = 1'b0;
        while (1) begin
            #1;
            if (gnt_o) begin
                granted = 1'b1;
                break;
            end
            stall++;
            if (may_withdraw || stall > int'(MaxGntStall) + 2) break;
            @(negedge clk_i);
        end
        check("gnt_stall", 64'(stall <= (rand_en_i ? int'(MaxGntStall) : 0)), 64'(1));
        if (!granted) begin
            req_i = 1'b0;
            @(negedge clk_i);
            return;
        end
        if (rvalid_o) b2b_cnt++;
        e.t_gnt = cyc;
        e.rdata = '0;
        e.err   = 1'b0;
        if (addr >= int'(NumWords)) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            e.rdata = model[addr];
        end
        if (rand_en_i) begin
            e.lat_min = 2;
            e.lat_max = int'(MaxLatency) + 1;
        end else begin
            l_fix = int'(fixed_lat_i);
            if (l_fix == 0) l_fix = 1;
            if (l_fix > int'(MaxLatency)) l_fix = int'(MaxLatency);
            e.lat_min = l_fix + 1;
            e.lat_max = l_fix + 1;
        end
        sb.push_back(e);
        save_lat  = fixed_lat_i;
        save_mode = rand_en_i;
        @(posedge clk_i);
        #1;
        req_i   = 1'b0;
        wdata_i = ~wd;
        if (perturb) begin
            fixed_lat_i = ~fixed_lat_i;
            rand_en_i   = ~rand_en_i;
        end
        found = 1'b0;
        for (int k = 0; k < int'(MaxLatency) + 4; k++) begin
            @(negedge clk_i);
            if (rvalid_o) begin
                found = 1'b1;
                break;
            end
            check("quiet_outputs", {31'b0, err_o, rdata_o}, 64'(0));
        end
        fixed_lat_i = save_lat;
        rand_en_i   = save_mode;
        got = sb.pop_front();
        if (!found) begin
            check("rvalid_timeout", 64'(0), 64'(1));
            return;
        end
        lat = cyc - got.t_gnt;
        check("latency", 64'(lat >= got.lat_min && lat <= got.lat_max), 64'(1));
        check("rdata", 64'(rdata_o), 64'(got.rdata));
        check("err", 64'(err_o), 64'(got.err));
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_i       = 1'b0;
        we_i        = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        be_i        = '0;
        rand_en_i   = 1'b0;
        fixed_lat_i = LatWidth'(3);

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Fixed L=3: full write, read back, partial write, empty-mask write
        txn(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0);
        txn(1'b1, 5, 32'h11223344, 4'b0101, 1'b0, 1'b0);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0);
        check("partial_model", 64'(model[5]), 64'(32'hDE22BE44));
        txn(1'b1, 5, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0);

        // Latency clamps and mid-transaction attribute changes
        fixed_lat_i = LatWidth'(0);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0);
        fixed_lat_i = LatWidth'(31);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b0);
        fixed_lat_i = LatWidth'(16);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b1);
        fixed_lat_i = LatWidth'(1);
        txn(1'b0, 5, 32'h0, 4'h0, 1'b0, 1'b1);

        // Fill array back-to-back, then out-of-range read/write
        fixed_lat_i = LatWidth'(0);
        for (int i = 0; i < int'(NumWords); i++) begin
            txn(1'b1, i, (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000, 4'hF, 1'b0, 1'b0);
        end
        txn(1'b0, 1000, 32'h0, 4'h0, 1'b0, 1'b0);
        txn(1'b1, 1023, 32'hBAD0BAD0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < int'(NumWords); i++) begin
            txn(1'b0, i, 32'h0, 4'h0, 1'b0, 1'b0);
        end

        // Random grant/latency mode
        rand_en_i = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), $urandom,
                4'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset during a write's wait phase drops the write
        repeat (2) @(negedge clk_i);
        rand_en_i   = 1'b0;
        fixed_lat_i = LatWidth'(8);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = AddrWidth'(7);
        wdata_i = 32'hCAFEF00D;
        be_i    = 4'hF;
        #1;
        check("rst_test_gnt", 64'(gnt_o), 64'(1));
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrst_rvalid", 64'(rvalid_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            check("post_rst_rvalid", 64'(rvalid_o), 64'(0));
        end
        txn(1'b0, 7, 32'h0, 4'h0, 1'b0, 1'b0);

        check("b2b_seen", 64'(b2b_cnt > 0), 64'(1));
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
